// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The issuing logic drives through the master modport; the divider uses slave.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Accepts a request only in IDLE, runs WIDTH iterations, then pulses done for
// one cycle. A zero divisor short-circuits to DONE with quotient all ones and
// remainder equal to the dividend.
// Optional feature: define DIV_SIGNED_EN for two's-complement (truncating)
// division; without it all operands are unsigned and no sign logic exists.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  seq_divider_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;    // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dsr_q, dsr_d;      // latched divisor (magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

`ifdef DIV_SIGNED_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
`endif

  logic [WIDTH-1:0] opa_mag, opb_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_step, r_step;
  logic [WIDTH-1:0] quo_load, rem_load;

  // Operand magnitudes captured at accept (identity in the unsigned build).
  always_comb begin
`ifdef DIV_SIGNED_EN
    opa_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    opb_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;
`else
    opa_mag = bus.dividend;
    opb_mag = bus.divisor;
`endif
  end

  // One restoring step; trial is one bit wider so its MSB is the borrow.
  always_comb begin
    shifted = {prem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    q_step  = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    r_step  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    quo_load = q_neg_q ? (~q_step + 1'b1) : q_step;
    rem_load = r_neg_q ? (~r_step + 1'b1) : r_step;
`else
    quo_load = q_step;
    rem_load = r_step;
`endif
  end

  // Next-state and datapath control for IDLE -> RUN -> DONE.
  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d  = opa_mag;
          dsr_d  = opb_mag;
          prem_d = '0;
          cnt_d  = CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
          q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          r_neg_d = bus.dividend[WIDTH-1];
`endif
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        prem_d = r_step;
        dvd_d  = q_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = quo_load;
          rem_d   = rem_load;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`endif
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a WIDTH=32 and a WIDTH=8 instance.
// Drivers push expected results (from plain arithmetic) into per-unit queues;
// a negedge monitor pops and compares whenever done is seen.
module tb_seq_divider;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) if32 ();
  seq_divider_if #(.WIDTH(8))  if8 ();

  seq_divider #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t last[2];
  bit   post[2];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: truncating division from the operand rules, zero divisor special-cased.
  function automatic exp_t ref_div(input logic [31:0] a_in, input logic [31:0] b_in, input int w);
    exp_t        e;
    logic [31:0] mask;
`ifdef DIV_SIGNED_EN
    longint      sa, sb;
`endif
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    e.a   = a_in & mask;
    e.b   = b_in & mask;
    e.due = 0;
    if (e.b == 32'd0) begin
      e.q = mask;
      e.r = e.a;
      e.z = 1'b1;
      return e;
    end
    e.z = 1'b0;
`ifdef DIV_SIGNED_EN
    sa = longint'(e.a);
    if (e.a[w-1]) sa = sa - (longint'(1) << w);
    sb = longint'(e.b);
    if (e.b[w-1]) sb = sb - (longint'(1) << w);
    e.q = 32'(sa / sb) & mask;
    e.r = 32'(sa % sb) & mask;
`else
    e.q = e.a / e.b;
    e.r = e.a % e.b;
`endif
    return e;
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 0) ? if32.busy : if8.busy;
  endfunction

  task automatic drv(input int u, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (u == 0) begin
      if32.start = s; if32.dividend = a; if32.divisor = b;
    end else begin
      if8.start = s; if8.dividend = a[7:0]; if8.divisor = b[7:0];
    end
  endtask

  task automatic push_exp(input int u, input exp_t e);
    if (u == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge with the unit idle (or after a timeout).
  task automatic wait_idle(input int u);
    for (int i = 0; i < 200; i++) begin
      if (!busy_of(u)) return;
      @(negedge clk);
    end
    check((u == 0) ? "w32 idle_timeout" : "w8 idle_timeout", {31'd0, busy_of(u)}, 32'd0);
  endtask

  // Issue one request; start is high for exactly one accepting edge.
  task automatic issue(input int u, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   w;
    w = (u == 0) ? 32 : 8;
    wait_idle(u);
    drv(u, 1'b1, a, b);
    e = ref_div(a, b, w);
    e.due = cyc + 1 + (e.z ? 0 : w);
    push_exp(u, e);
    @(negedge clk);
    drv(u, 1'b0, $urandom, $urandom);   // operand noise while running must not matter
    check((u == 0) ? "w32 busy_on_accept" : "w8 busy_on_accept", {31'd0, busy_of(u)}, 32'd1);
  endtask

  // Monitor for one unit: compare on done, then check the pulse ended and results held.
  task automatic mon(input int u);
    logic [31:0] aq, ar;
    logic        ad, ab, az;
    string       t;
    exp_t        e;
    t = (u == 0) ? "w32 " : "w8 ";
    if (u == 0) begin
      aq = if32.quotient; ar = if32.remainder; ad = if32.done; ab = if32.busy; az = if32.div_by_zero;
    end else begin
      aq = {24'd0, if8.quotient}; ar = {24'd0, if8.remainder};
      ad = if8.done; ab = if8.busy; az = if8.div_by_zero;
    end
    if (post[u]) begin
      post[u] = 1'b0;
      check({t, "done_one_cycle"}, {31'd0, ad}, 32'd0);
      check({t, "busy_after_done"}, {31'd0, ab}, 32'd0);
      check({t, "quotient_held"}, aq, last[u].q);
    end else if (ad) begin
      if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0)) begin
        check({t, "spurious_done"}, {31'd0, ad}, 32'd0);
      end else begin
        e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
        check({t, "done_cycle"}, cyc, e.due);
        check({t, "quotient"}, aq, e.q);
        check({t, "remainder"}, ar, e.r);
        check({t, "div_by_zero"}, {31'd0, az}, {31'd0, e.z});
        last[u] = e;
        post[u] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (sb0.size() == 0 && sb1.size() == 0 && !post[0] && !post[1]) return;
      @(negedge clk);
    end
    check("drain_timeout", sb0.size() + sb1.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "w32 busy"},      {31'd0, if32.busy}, 32'd0);
    check({t, "w32 done"},      {31'd0, if32.done}, 32'd0);
    check({t, "w32 quotient"},  if32.quotient, 32'd0);
    check({t, "w32 remainder"}, if32.remainder, 32'd0);
    check({t, "w32 dbz"},       {31'd0, if32.div_by_zero}, 32'd0);
    check({t, "w8 busy"},       {31'd0, if8.busy}, 32'd0);
    check({t, "w8 quotient"},   {24'd0, if8.quotient}, 32'd0);
    check({t, "w8 remainder"},  {24'd0, if8.remainder}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   k;
    logic [31:0] a, b;

    reset = 1'b1;
    drv(0, 1'b0, 32'd0, 32'd0);
    drv(1, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_reset_vals("reset ");
    reset = 1'b0;
    @(negedge clk);

    // WIDTH=32 directed cases
    issue(0, 32'd108, 32'd31);
    issue(0, 32'h1234_5678, 32'd0);
    issue(0, 32'hFFFF_FFFF, 32'd1);
    // start held during RUN with new operands: only taken once the unit is idle
    drv(0, 1'b1, 32'd50, 32'd5);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!if32.busy) break;
    end
    e = ref_div(32'd50, 32'd5, 32);
    e.due = cyc + 1 + 32;
    sb0.push_back(e);
    @(negedge clk);
    drv(0, 1'b0, 32'd0, 32'd0);
`ifdef DIV_SIGNED_EN
    issue(0, 32'hFFFF_FFF9, 32'd2);
    issue(0, 32'd7, 32'hFFFF_FFFE);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF);
`endif

    // WIDTH=8 directed cases
    issue(1, 32'd200, 32'd7);
    issue(1, 32'd5, 32'd9);
    issue(1, 32'hAB, 32'd0);
    issue(1, 32'h80, 32'hFF);

    // Randomized traffic on both units
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 30; n++) begin
        a = $urandom;
        case ($urandom_range(0, 3))
          0:       b = 32'd0;
          1:       b = $urandom_range(1, 15);
          2:       b = $urandom;
          default: b = a >> $urandom_range(0, 6);
        endcase
        issue(u, a, b);
      end
    end
    drain();

    // Reset ten edges into a 1000/7 divide, then redo it
    issue(0, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_vals("abort ");
    sb0.delete();
    post[0] = 1'b0;
    post[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    k = cyc;
    issue(0, 32'd1000, 32'd7);
    check("w32 accept_after_abort", cyc, k + 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
